// File: rtl/onehot_decode_pipe.sv
// Pipelined index-to-vector decoder: expands an IDX_W-bit index into a one-hot or
// thermometer [idx:0] vector, one index bit per stage (MSB first), 1 beat/cycle.
module onehot_decode_pipe #(
  parameter int unsigned IDX_W = 10  // must be >= 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  output logic                  in_ready,
  input  logic [IDX_W-1:0]      idx_in,
  input  logic                  mode_in,
  input  logic                  zero_in,
  output logic                  valid_out,
  input  logic                  out_ready,
  output logic [2**IDX_W-1:0]   out_vec
);

  localparam int unsigned WIDTH = 2 ** IDX_W;
  localparam int unsigned HALF  = WIDTH / 2;
  localparam int unsigned NSTG  = IDX_W - 1;
  localparam int unsigned LAST  = IDX_W - 1;

  // Registered stages 0..IDX_W-2; the final expansion feeds out_vec directly so the
  // output register is the last pipeline stage. Stage k uses only the low 2**(k+1) bits.
  logic [HALF-1:0]  oh_q    [NSTG];
  logic [HALF-1:0]  lo_q    [NSTG];
  logic [IDX_W-1:0] idx_q   [NSTG];
  logic             mode_q  [NSTG];
  logic [NSTG-1:0]  valid_q;

  logic [HALF-1:0]  src_oh   [IDX_W];
  logic [HALF-1:0]  src_lo   [IDX_W];
  logic [IDX_W-1:0] src_idx  [IDX_W];
  logic             src_mode [IDX_W];
  logic [IDX_W-1:0] src_valid;
  logic [IDX_W-1:0] dbit;
  logic [WIDTH-1:0] exp_oh   [IDX_W];
  logic [WIDTH-1:0] exp_lo   [IDX_W];

  logic stall;
  logic advance;

  assign stall    = valid_out & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = ~stall;

  // Expansion inputs: the seed for stage 0, the previous stage registers otherwise.
  // zero_in folds into the seed, so a zero beat expands to all-zero in both modes.
  always_comb begin
    src_oh[0]    = {{(HALF-1){1'b0}}, ~zero_in};
    src_lo[0]    = '0;
    src_idx[0]   = idx_in;
    src_mode[0]  = mode_in;
    src_valid[0] = valid_in;
    for (int k = 1; k < IDX_W; k++) begin
      src_oh[k]    = oh_q[k-1];
      src_lo[k]    = lo_q[k-1];
      src_idx[k]   = idx_q[k-1];
      src_mode[k]  = mode_q[k-1];
      src_valid[k] = valid_q[k-1];
    end
    for (int k = 0; k < IDX_W; k++) begin
      dbit[k] = src_idx[k][IDX_W-1-k];
    end
  end

  // Each set bit b splits into blocks 2b+1 (upper, d=1) and 2b (lower, d=0);
  // choosing the upper block marks the lower one as entirely below the index.
  always_comb begin
    for (int k = 0; k < IDX_W; k++) begin
      exp_oh[k] = '0;
      exp_lo[k] = '0;
      for (int b = 0; b < HALF; b++) begin
        exp_oh[k][2*b+1] = src_oh[k][b] & dbit[k];
        exp_oh[k][2*b]   = src_oh[k][b] & ~dbit[k];
        exp_lo[k][2*b+1] = src_lo[k][b];
        exp_lo[k][2*b]   = src_lo[k][b] | (src_oh[k][b] & dbit[k]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      valid_out <= 1'b0;
      out_vec   <= '0;
    end else if (advance) begin
      valid_q[0] <= valid_in;
      for (int k = 1; k < NSTG; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
      valid_out <= src_valid[LAST];
      if (src_valid[LAST]) begin
        out_vec <= exp_oh[LAST] | (src_mode[LAST] ? exp_lo[LAST] : '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k < NSTG; k++) begin
        oh_q[k]   <= exp_oh[k][HALF-1:0];
        lo_q[k]   <= exp_lo[k][HALF-1:0];
        idx_q[k]  <= src_idx[k];
        mode_q[k] <= src_mode[k];
      end
    end
  end

endmodule

// File: tb/tb_onehot_decode_pipe.sv
// Scoreboard bench for onehot_decode_pipe: directed plus random beats checked against
// a plain bit-loop reference and a highest-set-bit round-trip model.
module tb_onehot_decode_pipe;
  localparam int IDX_W = 10;
  localparam int WIDTH = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             valid_in = 1'b0;
  logic             in_ready;
  logic [IDX_W-1:0] idx_in = '0;
  logic             mode_in = 1'b0;
  logic             zero_in = 1'b0;
  logic             valid_out;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_vec;

  always #5 clk = ~clk;

  onehot_decode_pipe #(.IDX_W(IDX_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .in_ready  (in_ready),
    .idx_in    (idx_in),
    .mode_in   (mode_in),
    .zero_in   (zero_in),
    .valid_out (valid_out),
    .out_ready (out_ready),
    .out_vec   (out_vec)
  );

  typedef struct {
    logic [WIDTH-1:0] vec;
    int               idx;
    bit               zero;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  function automatic logic [WIDTH-1:0] ref_vec(int idx, bit mode, bit zero);
    logic [WIDTH-1:0] v = '0;
    if (!zero)
      for (int i = 0; i < WIDTH; i++)
        if (i == idx || (mode && i < idx)) v[i] = 1'b1;
    return v;
  endfunction

  // Find-first-set counterpart: index of the most significant set bit, -1 if none.
  function automatic int hi_bit(logic [WIDTH-1:0] v);
    int r = -1;
    for (int i = 0; i < WIDTH; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic chk_int(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got hi=%0d ones=%0d low=%h expected hi=%0d ones=%0d low=%h (t=%0t)",
               name, hi_bit(act), $countones(act), act[31:0],
               hi_bit(exp), $countones(exp), exp[31:0], $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && valid_out && out_ready) begin
      if (sb.size() == 0) begin
        chk_int("unexpected_beat", 1, 0);
      end else begin
        e = sb.pop_front();
        chk_vec("out_vec", out_vec, e.vec);
        if (!e.zero) chk_int("round_trip", hi_bit(out_vec), e.idx);
      end
    end
  end

  task automatic send(int idx, bit mode, bit zero);
    bit ok = 1'b0;
    valid_in = 1'b1;
    idx_in   = idx[IDX_W-1:0];
    mode_in  = mode;
    zero_in  = zero;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) sb.push_back('{vec: ref_vec(idx, mode, zero), idx: idx, zero: zero});
    else chk_int("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && sb.size() != 0; n++) @(negedge clk);
    chk_int("drain_left", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int  c;
  int  run;
  bit  done;
  logic [WIDTH-1:0] held;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_int("rst_valid_out", valid_out, 0);
    chk_vec("rst_out_vec", out_vec, '0);
    chk_int("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single beat latency and following bubble
    send(0, 1'b0, 1'b0);
    for (c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (valid_out) break;
    end
    chk_int("latency", c, 10);
    @(negedge clk);
    chk_int("bubble_valid_out", valid_out, 0);
    chk_vec("bubble_hold", out_vec, 1);
    @(posedge clk);
    #1;

    // Thermometer boundaries
    send(1023, 1'b1, 1'b0);
    send(5, 1'b1, 1'b0);
    send(0, 1'b1, 1'b0);
    send(1023, 1'b0, 1'b0);
    send(300, 1'b1, 1'b1);
    drain();

    // Back-to-back stream
    run = 0;
    fork
      begin
        for (int i = 0; i < 64; i++) send(i, 1'b0, 1'b0);
      end
      begin
        for (int n = 0; n < 200 && !valid_out; n++) @(negedge clk);
        while (valid_out && run < 100) begin
          run++;
          @(negedge clk);
        end
      end
    join
    chk_int("stream_run", run, 64);
    drain();

    // Backpressure mid-stream
    fork
      begin
        for (int i = 0; i < 20; i++) send($urandom_range(0, WIDTH - 1), $urandom_range(0, 1), 1'b0);
      end
      begin
        repeat (14) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
          @(negedge clk);
          chk_int("stall_in_ready", in_ready, 0);
          chk_int("stall_valid_out", valid_out, 1);
          if (k == 0) held = out_vec;
          else chk_vec("stall_hold", out_vec, held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with beats in flight
    for (int i = 0; i < 5; i++) send($urandom_range(1, WIDTH - 1), 1'b1, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_int("midrst_valid_out", valid_out, 0);
    chk_vec("midrst_out_vec", out_vec, '0);
    repeat (30) @(negedge clk);
    @(posedge clk);
    #1;

    // Random traffic with random backpressure and idle gaps
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
          send($urandom_range(0, WIDTH - 1), $urandom_range(0, 1), $urandom_range(0, 15) == 0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    repeat (15) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
